// File: rtl/window_buffer_kxc.sv
// window_buffer_kxc
// Multi-channel sliding-window generator. Each write supplies one padded pixel
// per channel; the block keeps four delayed rows per channel and a 5x5 shift
// register per channel, and emits a registered KxK window (K = 3 or 5) at
// every position selected by the run-time kernel size and stride.
//
// Handshake: wr_en is a valid-only strobe with no back-pressure. Every cycle
// with wr_en=1 and flush=0 consumes input_pixels. data_valid is a one-cycle
// pulse that qualifies output_window and has no ready; output_window holds its
// value until the next pulse.
module window_buffer_kxc #(
  parameter int BITSIZE  = 14,
  parameter int CHANNELS = 16,
  parameter int MAX_ROW  = 114,
  parameter int ROW_W    = 7
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [CHANNELS*BITSIZE-1:0]        input_pixels,
  input  logic                               kernel_sel,
  input  logic                               stride,
  input  logic [ROW_W-1:0]                   row_size,
  input  logic [ROW_W-1:0]                   plane_rows,
  input  logic                               zero_fill,
  input  logic                               flush,
  output logic                               data_valid,
  output logic                               depth_window_done,
  output logic [CHANNELS*25*BITSIZE-1:0]     output_window
);

  localparam int AW  = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;
  localparam int PW  = CHANNELS * BITSIZE;
  localparam int WW  = 25 * BITSIZE;
  localparam int RW1 = ROW_W + 1;
  localparam logic [ROW_W-1:0] ONE = ROW_W'(1);

  // Write position inside the current plane
  logic [ROW_W-1:0] r_q, r_d;
  logic [ROW_W-1:0] c_q, c_d;

  // Per-plane configuration, captured on the plane's first write
  logic             k5_q, k5_d;
  logic             s2_q, s2_d;
  logic [ROW_W-1:0] w_q, w_d;
  logic [ROW_W-1:0] h_q, h_d;

  // Registered outputs
  logic                      dv_q, dv_d;
  logic                      done_q, done_d;
  logic [CHANNELS*WW-1:0]    win_q, win_d;

  // 5x5 shift register per channel: [row][col], row 4 / col 4 newest
  logic [BITSIZE-1:0] sr_q [CHANNELS][5][5];
  logic [BITSIZE-1:0] sr_d [CHANNELS][5][5];

  // Four delayed rows, addressed by column. lb_q[0] is the previous row,
  // lb_q[3] is four rows back. No reset: contents are only ever consumed
  // once the plane has refilled them.
  logic [PW-1:0] lb_q [4][MAX_ROW];

  logic             wr_fire;
  logic             first_px;
  logic             k5_eff;
  logic             s2_eff;
  logic [ROW_W-1:0] w_eff;
  logic [ROW_W-1:0] h_eff;
  logic [AW-1:0]    addr;
  logic [PW-1:0]    wdata;
  logic [ROW_W-1:0] km1;
  logic             win_ok;
  logic             done_ok;
  logic [RW1-1:0]   step;
  logic [RW1-1:0]   r_next_win;
  logic [RW1-1:0]   c_next_win;
  logic             last_col;
  logic             last_row;

  // Qualify the write and select the configuration governing this write
  always_comb begin
    wr_fire  = wr_en && !flush;
    first_px = (r_q == '0) && (c_q == '0);
    k5_eff   = first_px ? kernel_sel : k5_q;
    s2_eff   = first_px ? stride     : s2_q;
    w_eff    = first_px ? row_size   : w_q;
    h_eff    = first_px ? plane_rows : h_q;
    addr     = AW'(c_q);
    wdata    = zero_fill ? '0 : input_pixels;
  end

  // Window-position test and last-window test for the current write
  always_comb begin
    km1        = k5_eff ? ROW_W'(4) : ROW_W'(2);
    step       = s2_eff ? RW1'(2) : RW1'(1);
    r_next_win = {1'b0, r_q} + step;
    c_next_win = {1'b0, c_q} + step;
    // K-1 is even, so parity of (r-K+1) equals parity of r.
    win_ok     = (r_q >= km1) && (c_q >= km1) &&
                 (!s2_eff || (!r_q[0] && !c_q[0]));
    done_ok    = (r_next_win >= {1'b0, h_eff}) && (c_next_win >= {1'b0, w_eff});
    last_col   = (c_q == (w_eff - ONE));
    last_row   = (r_q == (h_eff - ONE));
  end

  // Row/column counters and configuration capture
  always_comb begin
    r_d  = r_q;
    c_d  = c_q;
    k5_d = k5_q;
    s2_d = s2_q;
    w_d  = w_q;
    h_d  = h_q;
    if (flush) begin
      r_d = '0;
      c_d = '0;
    end else if (wr_en) begin
      if (first_px) begin
        k5_d = kernel_sel;
        s2_d = stride;
        w_d  = row_size;
        h_d  = plane_rows;
      end
      if (last_col) begin
        c_d = '0;
        r_d = last_row ? '0 : (r_q + ONE);
      end else begin
        c_d = c_q + ONE;
      end
    end
  end

  // Shift a new column (four delayed rows plus the incoming pixel) into the window
  always_comb begin
    sr_d = sr_q;
    if (wr_fire) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        for (int i = 0; i < 5; i++) begin
          for (int j = 0; j < 4; j++) begin
            sr_d[ch][i][j] = sr_q[ch][i][j+1];
          end
        end
        for (int i = 0; i < 4; i++) begin
          sr_d[ch][i][4] = lb_q[3-i][addr][ch*BITSIZE +: BITSIZE];
        end
        sr_d[ch][4][4] = wdata[ch*BITSIZE +: BITSIZE];
      end
    end
  end

  // Build the next output window and its qualifiers
  always_comb begin
    win_d  = win_q;
    dv_d   = 1'b0;
    done_d = 1'b0;
    if (wr_fire && win_ok) begin
      dv_d   = 1'b1;
      done_d = done_ok;
      win_d  = '0;
      if (k5_eff) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
              win_d[ch*WW + (i*5+j)*BITSIZE +: BITSIZE] = sr_d[ch][i][j];
            end
          end
        end
      end else begin
        // 3x3 uses the newest three rows and columns of the shift register.
        for (int ch = 0; ch < CHANNELS; ch++) begin
          for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
              win_d[ch*WW + (i*5+j)*BITSIZE +: BITSIZE] = sr_d[ch][i+2][j+2];
            end
          end
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q    <= '0;
      c_q    <= '0;
      k5_q   <= 1'b0;
      s2_q   <= 1'b0;
      w_q    <= '0;
      h_q    <= '0;
      dv_q   <= 1'b0;
      done_q <= 1'b0;
      win_q  <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        for (int i = 0; i < 5; i++) begin
          for (int j = 0; j < 5; j++) begin
            sr_q[ch][i][j] <= '0;
          end
        end
      end
    end else begin
      r_q    <= r_d;
      c_q    <= c_d;
      k5_q   <= k5_d;
      s2_q   <= s2_d;
      w_q    <= w_d;
      h_q    <= h_d;
      dv_q   <= dv_d;
      done_q <= done_d;
      win_q  <= win_d;
      sr_q   <= sr_d;
    end
  end

  // Line-buffer update: push the column down one row at the write address
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      lb_q[0][addr] <= wdata;
      for (int k = 1; k < 4; k++) begin
        lb_q[k][addr] <= lb_q[k-1][addr];
      end
    end
  end

  assign data_valid        = dv_q;
  assign depth_window_done = done_q;
  assign output_window     = win_q;

endmodule

// File: tb/tb_window_buffer_kxc.sv
// Directed bench for window_buffer_kxc with two channels. A small plane model
// (write counters, stored pixels, window rule) predicts data_valid,
// depth_window_done and output_window every cycle; hand-computed constants
// check window counts, first-window latency and selected taps.
module tb_window_buffer_kxc;

  localparam int B    = 14;
  localparam int CH   = 2;
  localparam int MAXR = 114;
  localparam int RW   = 7;
  localparam int WW   = 25 * B;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [CH*B-1:0]   input_pixels;
  logic              kernel_sel;
  logic              stride;
  logic [RW-1:0]     row_size;
  logic [RW-1:0]     plane_rows;
  logic              zero_fill;
  logic              flush;
  logic              data_valid;
  logic              depth_window_done;
  logic [CH*WW-1:0]  output_window;

  window_buffer_kxc #(
    .BITSIZE (B),
    .CHANNELS(CH),
    .MAX_ROW (MAXR),
    .ROW_W   (RW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .input_pixels     (input_pixels),
    .kernel_sel       (kernel_sel),
    .stride           (stride),
    .row_size         (row_size),
    .plane_rows       (plane_rows),
    .zero_fill        (zero_fill),
    .flush            (flush),
    .data_valid       (data_valid),
    .depth_window_done(depth_window_done),
    .output_window    (output_window)
  );

  // clock
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // plane model
  int               br, bc, bw, bh;
  logic             bk5, bs2;
  logic [B-1:0]     mem [CH][16][16];
  logic             exp_dv, exp_done;
  logic [CH*WW-1:0] exp_win;

  // observation bookkeeping
  int               dv_cnt, done_cnt, first_idx, cur_idx;
  logic             seen_first;
  logic [CH*WW-1:0] first_win, last_win;

  int s1_first [9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
  int s4_first [9] = '{0, 0, 0, 0, 7, 8, 0, 13, 14};

  function automatic int tap(input logic [CH*WW-1:0] w, input int ch, input int i, input int j);
    logic signed [B-1:0] v;
    v = w[ch*WW + (i*5+j)*B +: B];
    return int'(v);
  endfunction

  task automatic check_eq(input string name, input int got, input int want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, got, want);
    end
  endtask

  task automatic model_step();
    int k, s;
    exp_dv   = 1'b0;
    exp_done = 1'b0;
    if (!rst) begin
      br = 0; bc = 0; bw = 0; bh = 0; bk5 = 1'b0; bs2 = 1'b0;
      exp_win = '0;
      return;
    end
    if (flush) begin
      br = 0; bc = 0;
      return;
    end
    if (!wr_en) return;
    if (br == 0 && bc == 0) begin
      bk5 = kernel_sel; bs2 = stride;
      bw = int'(row_size); bh = int'(plane_rows);
    end
    for (int ch = 0; ch < CH; ch++)
      mem[ch][br][bc] = zero_fill ? '0 : input_pixels[ch*B +: B];
    k = bk5 ? 5 : 3;
    s = bs2 ? 2 : 1;
    if (br >= k-1 && bc >= k-1 && (s == 1 || (((br-k+1) % 2 == 0) && ((bc-k+1) % 2 == 0)))) begin
      exp_dv   = 1'b1;
      exp_done = (br + s > bh - 1) && (bc + s > bw - 1);
      exp_win  = '0;
      for (int ch = 0; ch < CH; ch++)
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            exp_win[ch*WW + (i*5+j)*B +: B] = mem[ch][br-k+1+i][bc-k+1+j];
    end
    if (bc == bw - 1) begin
      bc = 0;
      if (br == bh - 1) br = 0; else br++;
    end else begin
      bc++;
    end
  endtask

  task automatic check_outputs();
    n_cmp++;
    assert (data_valid === exp_dv) else begin
      n_fail++;
      $error("FAIL data_valid: observed %0b expected %0b t=%0t", data_valid, exp_dv, $time);
    end
    n_cmp++;
    assert (depth_window_done === exp_done) else begin
      n_fail++;
      $error("FAIL depth_window_done: observed %0b expected %0b t=%0t", depth_window_done, exp_done, $time);
    end
    n_cmp++;
    assert (output_window === exp_win) else begin
      n_fail++;
      $error("FAIL window t=%0t: observed %h expected %h", $time, output_window, exp_win);
    end
    if (data_valid === 1'b1) begin
      dv_cnt++;
      last_win = output_window;
      if (!seen_first) begin
        seen_first = 1'b1;
        first_win  = output_window;
        first_idx  = cur_idx;
      end
    end
    if (depth_window_done === 1'b1) done_cnt++;
  endtask

  // driver: apply one cycle of inputs, then check the registered response
  task automatic cycle(input logic wr, input logic zf, input logic fl, input logic rs,
                       input int idx, input int p0, input int p1);
    rst          = rs;
    wr_en        = wr;
    zero_fill    = zf;
    flush        = fl;
    input_pixels = {B'(p1), B'(p0)};
    cur_idx      = idx;
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 0);
  endtask

  task automatic clear_stats();
    dv_cnt = 0; done_cnt = 0; first_idx = -1; seen_first = 1'b0;
    first_win = '0; last_win = '0;
  endtask

  task automatic write_plane(input int w, input int h, input logic k5, input logic s2,
                             input int gap_pct, input int zf_mode, input int flush_at,
                             input int rst_at, input logic toggle_cfg);
    int idx, p, g;
    idx = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        g = 0;
        while (g < 4 && gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
          idle(1);
          g++;
        end
        kernel_sel = (toggle_cfg && idx > 0) ? ~k5 : k5;
        stride     = (toggle_cfg && idx > 0) ? ~s2 : s2;
        row_size   = RW'(w);
        plane_rows = RW'(h);
        p = r * w + c;
        if (idx == flush_at) begin
          cycle(1'b1, 1'b0, 1'b1, 1'b1, idx, p, p + 100);
          return;
        end
        if (idx == rst_at) begin
          cycle(1'b1, 1'b0, 1'b0, 1'b0, idx, p, p + 100);
          return;
        end
        cycle(1'b1, (zf_mode != 0) && (r == 0 || c == 0), 1'b0, 1'b1, idx, p, p + 100);
        idx++;
      end
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; zero_fill = 1'b0; flush = 1'b0;
    input_pixels = '0; kernel_sel = 1'b0; stride = 1'b0;
    row_size = '0; plane_rows = '0;
    clear_stats();

    // reset state
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 0);
    idle(1);

    // 1: 6x6, K=3, s=1
    clear_stats();
    write_plane(6, 6, 1'b0, 1'b0, 0, 0, -1, -1, 1'b0);
    idle(2);
    check_eq("s1_windows", dv_cnt, 16);
    check_eq("s1_done", done_cnt, 1);
    check_eq("s1_first_idx", first_idx, 14);
    for (int k = 0; k < 9; k++) begin
      check_eq("s1_first_ch0", tap(first_win, 0, k/3, k%3), s1_first[k]);
      check_eq("s1_first_ch1", tap(first_win, 1, k/3, k%3), s1_first[k] + 100);
    end
    check_eq("s1_tap33_zero", tap(first_win, 0, 3, 3), 0);
    check_eq("s1_tap40_zero", tap(first_win, 1, 4, 0), 0);
    check_eq("s1_last_00", tap(last_win, 0, 0, 0), 21);
    check_eq("s1_last_22", tap(last_win, 0, 2, 2), 35);
    check_eq("s1_last_22_ch1", tap(last_win, 1, 2, 2), 135);

    // 2: 9x9, K=5, s=2
    clear_stats();
    write_plane(9, 9, 1'b1, 1'b1, 0, 0, -1, -1, 1'b0);
    idle(2);
    check_eq("s2_windows", dv_cnt, 9);
    check_eq("s2_done", done_cnt, 1);
    check_eq("s2_first_idx", first_idx, 40);
    check_eq("s2_first_00", tap(first_win, 0, 0, 0), 0);
    check_eq("s2_first_44", tap(first_win, 0, 4, 4), 40);
    check_eq("s2_first_44_ch1", tap(first_win, 1, 4, 4), 140);
    check_eq("s2_last_44", tap(last_win, 0, 4, 4), 80);
    check_eq("s2_last_00", tap(last_win, 0, 0, 0), 40);

    // 3: scenario 1 with random write gaps
    clear_stats();
    write_plane(6, 6, 1'b0, 1'b0, 50, 0, -1, -1, 1'b0);
    idle(2);
    check_eq("s3_windows", dv_cnt, 16);
    check_eq("s3_done", done_cnt, 1);
    check_eq("s3_first_idx", first_idx, 14);

    // 4: zero_fill on row 0 and column 0
    clear_stats();
    write_plane(6, 6, 1'b0, 1'b0, 0, 1, -1, -1, 1'b0);
    idle(2);
    check_eq("s4_windows", dv_cnt, 16);
    for (int k = 0; k < 9; k++) begin
      check_eq("s4_first_ch0", tap(first_win, 0, k/3, k%3), s4_first[k]);
      check_eq("s4_first_ch1", tap(first_win, 1, k/3, k%3), (s4_first[k] == 0) ? 0 : s4_first[k] + 100);
    end

    // 5: flush with the write of pixel 20, then a fresh plane
    clear_stats();
    write_plane(6, 6, 1'b0, 1'b0, 0, 0, 20, -1, 1'b0);
    idle(2);
    check_eq("s5_windows_before_flush", dv_cnt, 4);
    clear_stats();
    write_plane(6, 6, 1'b0, 1'b0, 0, 0, -1, -1, 1'b0);
    idle(2);
    check_eq("s5_windows", dv_cnt, 16);
    check_eq("s5_first_idx", first_idx, 14);
    for (int k = 0; k < 9; k++)
      check_eq("s5_first_ch0", tap(first_win, 0, k/3, k%3), s1_first[k]);

    // 6: back-to-back planes with mid-plane config toggling, then reset mid-plane
    clear_stats();
    write_plane(6, 6, 1'b0, 1'b0, 0, 0, -1, -1, 1'b1);
    write_plane(9, 9, 1'b1, 1'b1, 0, 0, -1, -1, 1'b1);
    idle(2);
    check_eq("s6_windows", dv_cnt, 25);
    check_eq("s6_done", done_cnt, 2);
    check_eq("s6_last_44", tap(last_win, 0, 4, 4), 80);
    clear_stats();
    write_plane(6, 6, 1'b0, 1'b0, 0, 0, -1, 10, 1'b0);
    idle(3);
    check_eq("s6_no_dv_after_reset", dv_cnt, 0);
    write_plane(6, 6, 1'b0, 1'b0, 0, 0, -1, -1, 1'b0);
    idle(2);
    check_eq("s6_refill_windows", dv_cnt, 16);
    check_eq("s6_refill_first_idx", first_idx, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/window_buffer_kxc.md
Name: window_buffer_kxc

Overview:
- Parametrised multi-channel sliding-window generator for the depthwise/conv datapath, successor to the fixed 16-channel 5x5 window FIFO.
- Accepts one padded pixel per channel per write and emits a registered KxK window for every channel.
- Kernel size (3 or 5) and stride (1 or 2) are selectable at run time per plane; row and column skipping for stride 2 is exact.
- Sits between the input feature-map reader and the MAC array.

Parameters:
- BITSIZE, 14, pixel width (signed fixed point).
- CHANNELS, 16, parallel channels per write.
- MAX_ROW, 114, maximum padded row width; sets line-buffer depth.
- ROW_W, 7, width of the row_size/plane_rows ports.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- wr_en  in  1  one pixel per channel written this cycle.
- input_pixels  in  CHANNELS*BITSIZE  channel k at bits [k*BITSIZE +: BITSIZE].
- kernel_sel  in  1  0 = 3x3, 1 = 5x5.
- stride  in  1  0 = stride 1, 1 = stride 2.
- row_size  in  ROW_W  padded row width W; legal range K..MAX_ROW.
- plane_rows  in  ROW_W  padded row count H; must be >= K.
- zero_fill  in  1  written pixels replaced by 0 (padding insertion).
- flush  in  1  abort the current plane.
- data_valid  out  1  one-cycle pulse: output_window holds a new window.
- depth_window_done  out  1  pulses together with data_valid on the plane's last window.
- output_window  out  CHANNELS*25*BITSIZE  channel k at [k*25*BITSIZE +: 25*BITSIZE]; tap (i,j) at index i*5+j; row 0 is oldest.

Behaviour:
- Reset (rst=0 at a clk edge):
  - data_valid, depth_window_done = 0; output_window = 0.
  - Row/column counters = 0; latched configuration cleared.
  - Line-buffer contents are don't-care.
  - Reset applied mid-plane discards the plane entirely.
- Configuration: kernel_sel, stride, row_size and plane_rows are latched on the first write of a plane (counters at 0,0). Changes during a plane are ignored.
- Write counters: each wr_en advances column c. At c = W-1, c wraps to 0 and r increments. At (H-1, W-1) both wrap to 0 and the next write starts a new plane. wr_en gaps of any length are legal; state holds.
- Line buffer: 4 delay rows of depth W per channel plus a 5x5 shift register per channel. In 3x3 mode only the rows needed are used.
- Window condition for a write at (r,c), with K = 3 or 5 and s = 1 or 2:
  - r >= K-1 and c >= K-1, and
  - for s = 2: (r-K+1) and (c-K+1) are both even.
- Latency: when the condition holds, data_valid = 1 on the following cycle. output_window then holds tap(i,j) = pixel(r-K+1+i, c-K+1+j) for i,j < K.
- In 3x3 mode, taps with i >= 3 or j >= 3 are 0.
- output_window is registered and holds its value until the next valid window.
- depth_window_done = data_valid AND the window's r+s > H-1 AND c+s > W-1.
- zero_fill: when high during a write, 0 is stored for every channel instead of input_pixels. Counters still advance.
- flush:
  - Clears counters and any pending data_valid next cycle; outputs hold their last window.
  - flush and wr_en in the same cycle: flush wins and the write is dropped.
- Pixel arithmetic: none. Data passes through bit-exact, signed.

Test Plan:
1. CHANNELS=2, K=3, s=1, W=H=6; pixel = r*6+c+100*ch.
   - First data_valid the cycle after write index 14 (r=2,c=2).
   - ch0 taps = 0,1,2,6,7,8,12,13,14; ch1 taps = 100..114 equivalents; taps outside 3x3 = 0.
   - 16 windows in total; depth_window_done with the 16th, one cycle after pixel 35.
2. K=5, s=2, W=H=9: windows only at r,c in {4,6,8}, giving 9 pulses.
   - First pulse after pixel 40 with tap(0,0) = 0 and tap(4,4) = 40.
   - Last window tap(4,4) = 80, with depth_window_done.
3. Random wr_en gaps (~50% duty) on scenario 1 → identical window sequence; data_valid is never asserted on a non-write cycle+1.
4. zero_fill high for row 0 and column 0 in scenario 1 → first window ch0 taps = 0,0,0,0,7,8,0,13,14.
5. flush asserted at pixel 20 together with wr_en, then a fresh plane → pixel 20 dropped; the new plane's first window equals scenario 1's first window.
6. Back-to-back planes: 6x6 K=3 s=1, then 9x9 K=5 s=2 with no idle cycles → 16 then 9 windows. Toggling kernel_sel mid-plane has no effect. Reset at pixel 10 → no data_valid until a new plane refills.
